// File: rtl/serial_link_phy_train_rx.sv
// Receive-side training checker and delay-sweep controller: sweeps the PHY delay code, checks a counter stream per step, picks the centre of the longest passing window.
// Optional feature macro: SERIAL_LINK_TRAIN_ERRCNT_EN (run every step to completion and accumulate a saturating mismatch count).
module serial_link_phy_train_rx #(
    parameter int NumLanes      = 8,
    parameter int NumSteps      = 16,
    parameter int SettleCycles  = 32,
    parameter int CheckLen      = 256,
    parameter int TimeoutCycles = 1024,
    localparam int W            = 2 * NumLanes,
    localparam int DW           = $clog2(NumSteps)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [W-1:0]        data_in_i,
    input  logic                data_in_valid_i,
    output logic                data_in_ready_o,
    output logic [DW-1:0]       delay_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                fail_o,
    output logic [NumSteps-1:0] pass_map_o,
    output logic [DW-1:0]       best_delay_o,
    output logic [15:0]         err_count_o
);

    localparam int CntMax = (SettleCycles > CheckLen) ? SettleCycles : CheckLen;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int IdleW  = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SEED, S_CHECK, S_NEXT, S_EVAL, S_DONE
    } stateT;

    stateT               r_state;
    stateT               w_stateNext;
    logic [DW-1:0]       r_step;
    logic [DW-1:0]       r_delay;
    logic [CntW-1:0]     r_cnt;
    logic [IdleW-1:0]    r_idle;
    logic [W-1:0]        r_exp;
    logic                r_stepPass;
    logic                r_busy;
    logic                r_done;
    logic                r_fail;
    logic [NumSteps-1:0] r_passMap;
    logic [DW-1:0]       r_bestDelay;
    logic [DW-1:0]       r_scanIdx;
    logic [DW:0]         r_curLen;
    logic [DW-1:0]       r_curStart;
    logic [DW:0]         r_bestLen;
    logic [DW-1:0]       r_bestStart;
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
    logic                r_stepFail;
    logic [15:0]         r_errCount;
`endif

    logic                w_wordOk;
    logic                w_lastWord;
    logic                w_timeout;
    logic                w_bit;
    logic [DW:0]         w_runLen;
    logic [DW-1:0]       w_runStart;
    logic                w_newBest;
    logic [DW:0]         w_bestLenN;
    logic [DW-1:0]       w_bestStartN;
    logic [DW-1:0]       w_bestDelay;

    assign w_wordOk   = (data_in_i == r_exp);
    assign w_lastWord = data_in_valid_i && (r_cnt == CntW'(CheckLen - 1));
    assign w_timeout  = !data_in_valid_i && (r_idle == IdleW'(TimeoutCycles - 1));

    // Run-length scan: a run only replaces the best when strictly longer, so ties keep the lowest start.
    assign w_bit        = r_passMap[r_scanIdx];
    assign w_runLen     = w_bit ? (r_curLen + 1'b1) : '0;
    assign w_runStart   = (r_curLen == '0) ? r_scanIdx : r_curStart;
    assign w_newBest    = w_bit && (w_runLen > r_bestLen);
    assign w_bestLenN   = w_newBest ? w_runLen : r_bestLen;
    assign w_bestStartN = w_newBest ? w_runStart : r_bestStart;
    assign w_bestDelay  = (w_bestLenN == '0) ? '0 :
                          DW'({1'b0, w_bestStartN} + ((w_bestLenN - 1'b1) >> 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) w_stateNext = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == CntW'(SettleCycles - 1)) w_stateNext = S_SEED;
            end
            S_SEED: begin
                if (data_in_valid_i) w_stateNext = S_CHECK;
                else if (w_timeout)  w_stateNext = S_NEXT;
            end
            S_CHECK: begin
                if (data_in_valid_i) begin
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
                    if (w_lastWord) w_stateNext = S_NEXT;
`else
                    if (w_lastWord || !w_wordOk) w_stateNext = S_NEXT;
`endif
                end else if (w_timeout) begin
                    w_stateNext = S_NEXT;
                end
            end
            S_NEXT: begin
                w_stateNext = (r_step == DW'(NumSteps - 1)) ? S_EVAL : S_SETTLE;
            end
            S_EVAL: begin
                if (r_scanIdx == DW'(NumSteps - 1)) w_stateNext = S_DONE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // r_stepPass is rewritten on every SEED/CHECK cycle so it holds the verdict of whichever word or timeout ends the step.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_step      <= '0;
            r_delay     <= '0;
            r_cnt       <= '0;
            r_idle      <= '0;
            r_exp       <= '0;
            r_stepPass  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_passMap   <= '0;
            r_bestDelay <= '0;
            r_scanIdx   <= '0;
            r_curLen    <= '0;
            r_curStart  <= '0;
            r_bestLen   <= '0;
            r_bestStart <= '0;
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
            r_stepFail  <= 1'b0;
            r_errCount  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_passMap <= '0;
                        r_done    <= 1'b0;
                        r_fail    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_step    <= '0;
                        r_delay   <= '0;
                        r_cnt     <= '0;
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
                        r_errCount <= '0;
`endif
                    end
                end
                S_SETTLE: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_idle <= '0;
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
                    r_stepFail <= 1'b0;
`endif
                end
                S_SEED: begin
                    r_stepPass <= 1'b0;
                    if (data_in_valid_i) begin
                        r_exp  <= data_in_i + 1'b1;
                        r_cnt  <= '0;
                        r_idle <= '0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (data_in_valid_i) begin
                        r_idle <= '0;
                        r_cnt  <= r_cnt + 1'b1;
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
                        r_stepPass <= w_wordOk && !r_stepFail;
                        if (w_wordOk) begin
                            r_exp <= r_exp + 1'b1;
                        end else begin
                            r_exp      <= data_in_i + 1'b1;
                            r_stepFail <= 1'b1;
                            if (r_errCount != 16'hFFFF) r_errCount <= r_errCount + 1'b1;
                        end
`else
                        r_stepPass <= w_wordOk;
                        r_exp      <= r_exp + 1'b1;
`endif
                    end else begin
                        r_idle     <= r_idle + 1'b1;
                        r_stepPass <= 1'b0;
                    end
                end
                S_NEXT: begin
                    r_passMap[r_step] <= r_stepPass;
                    r_cnt             <= '0;
                    if (r_step == DW'(NumSteps - 1)) begin
                        r_scanIdx   <= '0;
                        r_curLen    <= '0;
                        r_curStart  <= '0;
                        r_bestLen   <= '0;
                        r_bestStart <= '0;
                    end else begin
                        r_step  <= r_step + 1'b1;
                        r_delay <= r_step + 1'b1;
                    end
                end
                S_EVAL: begin
                    r_scanIdx   <= r_scanIdx + 1'b1;
                    r_curLen    <= w_runLen;
                    r_curStart  <= w_runStart;
                    r_bestLen   <= w_bestLenN;
                    r_bestStart <= w_bestStartN;
                    if (r_scanIdx == DW'(NumSteps - 1)) begin
                        r_bestDelay <= w_bestDelay;
                        r_delay     <= w_bestDelay;
                        r_fail      <= (w_bestLenN == '0);
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_in_ready_o = 1'b1;
    assign delay_o         = r_delay;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign fail_o          = r_fail;
    assign pass_map_o      = r_passMap;
    assign best_delay_o    = r_bestDelay;
`ifdef SERIAL_LINK_TRAIN_ERRCNT_EN
    assign err_count_o     = r_errCount;
`else
    assign err_count_o     = '0;
`endif

endmodule
